// File: rtl/yarp_pkg.sv
// Shared core package: vector row type, load/store sequencer state encoding
// and vector geometry constants.
package yarp_pkg;

  localparam int VEC_WORDS_PER_ROW = 4;

  typedef logic [127:0] vec_row_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R,
    DONE
  } vls_state_e;

endpackage

// File: rtl/vec_ldst_seq.sv
// Vector load/store sequencer: splits a ROWS x ROW_BITS transfer into 32-bit
// req/gnt/rvalid word accesses. Optional misaligned-base trap: VEC_LDST_ERR_EN.
module vec_ldst_seq
  import yarp_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int ROW_BITS   = 128,
  parameter int ROW_STRIDE = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start_load_i,
  input  logic                     start_store_i,
  input  logic [31:0]              base_addr_i,
  input  logic [ROWS*ROW_BITS-1:0] st_data_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [ROWS*ROW_BITS-1:0] ld_data_o,
  output logic                     err_o,
  output logic                     mem_req_o,
  output logic                     mem_wr_o,
  output logic [31:0]              mem_addr_o,
  output logic [31:0]              mem_wdata_o,
  input  logic                     mem_gnt_i,
  input  logic                     mem_rvalid_i,
  input  logic [31:0]              mem_rdata_i
);

  localparam int WPR = ROW_BITS / 32;
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int WW  = (WPR > 1) ? $clog2(WPR) : 1;

  vls_state_e    state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [WW-1:0] word_q, word_d;
  logic [31:0]   row_addr_q, row_addr_d;
  logic          wr_q, wr_d;
  logic [31:0]   st_buf_q [ROWS][WPR];
  logic [31:0]   st_buf_d [ROWS][WPR];
  logic [31:0]   ld_buf_q [ROWS][WPR];
  logic [31:0]   ld_buf_d [ROWS][WPR];

  logic        start;
  logic        last_word;
  logic        advance;
  logic        misaligned;
  logic [31:0] base_aligned;

  assign start     = start_load_i | start_store_i;
  assign last_word = (row_q == RW'(ROWS - 1)) && (word_q == WW'(WPR - 1));

`ifdef VEC_LDST_ERR_EN
  logic err_q, err_d;
  assign misaligned   = |base_addr_i[1:0];
  assign base_aligned = base_addr_i;
`else
  // Low address bits are simply dropped, so a misaligned base reads/writes
  // the enclosing word-aligned block.
  assign misaligned   = 1'b0;
  assign base_aligned = base_addr_i & 32'hFFFF_FFFC;
`endif

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    word_d     = word_q;
    row_addr_d = row_addr_q;
    wr_d       = wr_q;
    st_buf_d   = st_buf_q;
    ld_buf_d   = ld_buf_q;
    advance    = 1'b0;
`ifdef VEC_LDST_ERR_EN
    err_d      = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          wr_d       = ~start_load_i;
          row_d      = '0;
          word_d     = '0;
          row_addr_d = base_aligned;
          if (!start_load_i) begin
            for (int r = 0; r < ROWS; r++) begin
              for (int w = 0; w < WPR; w++) begin
                st_buf_d[r][w] = st_data_i[r*ROW_BITS + 32*w +: 32];
              end
            end
          end
          if (misaligned) begin
            state_d = DONE;
`ifdef VEC_LDST_ERR_EN
            err_d   = 1'b1;
`endif
          end else begin
            state_d = REQ;
          end
        end
      end

      REQ: begin
        if (mem_gnt_i) begin
          if (!wr_q) begin
            state_d = WAIT_R;
          end else if (last_word) begin
            state_d = DONE;
          end else begin
            advance = 1'b1;
          end
        end
      end

      WAIT_R: begin
        if (mem_rvalid_i) begin
          ld_buf_d[row_q][word_q] = mem_rdata_i;
          if (last_word) begin
            state_d = DONE;
          end else begin
            advance = 1'b1;
            state_d = REQ;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Row base is accumulated rather than multiplied; word offset is added on output.
    if (advance) begin
      if (word_q == WW'(WPR - 1)) begin
        word_d     = '0;
        row_d      = row_q + RW'(1);
        row_addr_d = row_addr_q + 32'(ROW_STRIDE);
      end else begin
        word_d     = word_q + WW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      row_q      <= '0;
      word_q     <= '0;
      row_addr_q <= '0;
      wr_q       <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        for (int w = 0; w < WPR; w++) begin
          st_buf_q[r][w] <= '0;
          ld_buf_q[r][w] <= '0;
        end
      end
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      word_q     <= word_d;
      row_addr_q <= row_addr_d;
      wr_q       <= wr_d;
      st_buf_q   <= st_buf_d;
      ld_buf_q   <= ld_buf_d;
    end
  end

`ifdef VEC_LDST_ERR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q & (state_q == DONE);
`else
  assign err_o = 1'b0;
`endif

  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign mem_req_o   = (state_q == REQ);
  assign mem_wr_o    = mem_req_o & wr_q;
  assign mem_addr_o  = row_addr_q + (32'(word_q) << 2);
  assign mem_wdata_o = st_buf_q[row_q][word_q];

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_ld_row
    for (genvar gj = 0; gj < WPR; gj++) begin : g_ld_word
      assign ld_data_o[gi*ROW_BITS + 32*gj +: 32] = ld_buf_q[gi][gj];
    end
  end

endmodule

// File: tb/tb_vec_ldst_seq.sv
// Self-checking bench for vec_ldst_seq: directed and randomized transfers
// against a word-level memory model and an address/data reference model.
module tb_vec_ldst_seq;

  localparam int ROWS     = 4;
  localparam int ROW_BITS = 128;
  localparam int STRIDE   = 16;
  localparam int WPR      = ROW_BITS / 32;
  localparam int NW       = ROWS * WPR;
  localparam int VB       = ROWS * ROW_BITS;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start_load_i, start_store_i;
  logic [31:0]   base_addr_i;
  logic [VB-1:0] st_data_i;
  logic          busy_o, done_o, err_o;
  logic [VB-1:0] ld_data_o;
  logic          mem_req_o, mem_wr_o;
  logic [31:0]   mem_addr_o, mem_wdata_o;
  logic          mem_gnt_i, mem_rvalid_i;
  logic [31:0]   mem_rdata_i;

  always #5 clk = ~clk;

  vec_ldst_seq #(
    .ROWS(ROWS), .ROW_BITS(ROW_BITS), .ROW_STRIDE(STRIDE)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .start_load_i(start_load_i), .start_store_i(start_store_i),
    .base_addr_i(base_addr_i), .st_data_i(st_data_i),
    .busy_o(busy_o), .done_o(done_o), .ld_data_o(ld_data_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_wr_o(mem_wr_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  int checks = 0;
  int errors = 0;

  // Responder knobs and observed access log
  int          gmax = 0;
  int          rmax = 0;
  bit          spur_en = 1'b0;
  logic [31:0] obs_addr[$];
  logic [31:0] obs_wdata[$];
  bit          obs_wr[$];

  logic [VB-1:0] exp_ld;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wide(input string tag, input logic [VB-1:0] obs, input logic [VB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model: the word at byte address A holds A.
  function automatic logic [VB-1:0] model_ld(input logic [31:0] base);
    logic [VB-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int w = 0; w < WPR; w++)
        v[r*ROW_BITS + 32*w +: 32] = base + 32'(r * STRIDE) + 32'(4 * w);
    return v;
  endfunction

  // Responder: random gnt/rvalid latency, one outstanding read, optional junk rvalid.
  initial begin : responder
    bit          pending;
    bit          hs;
    bit          held_valid;
    bit          held_wr;
    logic [31:0] paddr, held_addr, held_wdata;
    int          rv_wait, gnt_wait;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    pending      = 1'b0;
    held_valid   = 1'b0;
    rv_wait      = 0;
    gnt_wait     = 0;
    forever begin
      @(negedge clk);
      if (held_valid && mem_req_o) begin
        chk("hold_addr", mem_addr_o, held_addr);
        chk("hold_wdata", mem_wdata_o, held_wdata);
        chk("hold_wr", 32'(mem_wr_o), 32'(held_wr));
      end
      held_valid = reset_n && mem_req_o && !mem_gnt_i;
      held_addr  = mem_addr_o;
      held_wdata = mem_wdata_o;
      held_wr    = mem_wr_o;
      hs = reset_n && mem_req_o && mem_gnt_i;
      if (hs) begin
        obs_addr.push_back(mem_addr_o);
        obs_wdata.push_back(mem_wdata_o);
        obs_wr.push_back(mem_wr_o);
        if (!mem_wr_o) begin
          pending = 1'b1;
          paddr   = mem_addr_o;
          rv_wait = int'($urandom_range(0, unsigned'(rmax)));
        end
        gnt_wait = int'($urandom_range(0, unsigned'(gmax)));
      end
      @(posedge clk);
      #1;
      if (!reset_n) begin
        pending    = 1'b0;
        gnt_wait   = 0;
        held_valid = 1'b0;
      end
      if (pending && rv_wait == 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = paddr;
        pending      = 1'b0;
      end else begin
        if (pending) rv_wait--;
        mem_rvalid_i = spur_en && !pending && ($urandom_range(0, 3) == 0);
        mem_rdata_i  = $urandom;
      end
      if (mem_req_o && gnt_wait == 0) begin
        mem_gnt_i = 1'b1;
      end else begin
        mem_gnt_i = 1'b0;
        if (mem_req_o && gnt_wait > 0) gnt_wait--;
      end
    end
  end

  // Issue one start, then watch busy/done/err cycle by cycle (cycle 1 = first
  // cycle after the start is sampled). Optionally poke starts while busy.
  task automatic run_xfer(input bit ld, input bit st, input logic [31:0] base,
                          input logic [VB-1:0] sdata, input bit poke,
                          output int busy_n, output int done_cyc, output int done_n,
                          output int err_n, output int err_cyc);
    int cyc;
    obs_addr.delete();
    obs_wdata.delete();
    obs_wr.delete();
    busy_n = 0; done_cyc = 0; done_n = 0; err_n = 0; err_cyc = 0; cyc = 0;
    @(posedge clk);
    #1;
    start_load_i  = ld;
    start_store_i = st;
    base_addr_i   = base;
    st_data_i     = sdata;
    @(posedge clk);
    #1;
    start_load_i  = 1'b0;
    start_store_i = 1'b0;
    base_addr_i   = $urandom;
    st_data_i     = ~sdata;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start_load_i  = 1'b0;
      start_store_i = 1'b0;
      if (busy_o) busy_n++;
      if (done_o) begin done_n++; done_cyc = cyc; end
      if (err_o) begin err_n++; err_cyc = cyc; end
      if (!busy_o) break;
      if (poke && !done_o && $urandom_range(0, 3) == 0) begin
        start_load_i  = 1'($urandom_range(0, 1));
        start_store_i = 1'($urandom_range(0, 1));
      end
    end
    chk("xfer_timeout", 32'(cyc >= 2000), 32'd0);
    $display("xfer ld=%0d st=%0d base=%08h accesses=%0d busy=%0d done@%0d",
             ld, st, base, obs_addr.size(), busy_n, done_cyc);
  endtask

  task automatic check_accesses(input logic [31:0] base, input bit wr, input logic [VB-1:0] sdata);
    chk("n_access", 32'(obs_addr.size()), 32'(NW));
    for (int i = 0; i < obs_addr.size() && i < NW; i++) begin
      int r, w;
      r = i / WPR;
      w = i % WPR;
      chk("acc_addr", obs_addr[i], base + 32'(r * STRIDE) + 32'(4 * w));
      chk("acc_wr", 32'(obs_wr[i]), 32'(wr));
      if (wr) chk("acc_wdata", obs_wdata[i], sdata[r*ROW_BITS + 32*w +: 32]);
    end
  endtask

  initial begin : main
    int            busy_n, done_cyc, done_n, err_n, err_cyc, guard;
    logic [VB-1:0] sd;
    logic [127:0]  row0_exp;
    logic [31:0]   base;
    bit            is_ld;

    reset_n       = 1'b0;
    start_load_i  = 1'b0;
    start_store_i = 1'b0;
    base_addr_i   = '0;
    st_data_i     = '0;
    exp_ld        = '0;
    repeat (3) @(negedge clk);

    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_req", 32'(mem_req_o), 0);
    chk("rst_wr", 32'(mem_wr_o), 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk_wide("rst_ld", ld_data_o, '0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-wait load at 0x100
    run_xfer(1'b1, 1'b0, 32'h100, '0, 1'b0, busy_n, done_cyc, done_n, err_n, err_cyc);
    check_accesses(32'h100, 1'b0, '0);
    exp_ld = model_ld(32'h100);
    chk_wide("t1_ld", ld_data_o, exp_ld);
    row0_exp = 128'h0000010C_00000108_00000104_00000100;
    chk("t1_row0_lo", ld_data_o[31:0], row0_exp[31:0]);
    chk("t1_row0_hi", ld_data_o[127:96], row0_exp[127:96]);
    chk("t1_busy", 32'(busy_n), 33);
    chk("t1_done_cyc", 32'(done_cyc), 33);
    chk("t1_done_n", 32'(done_n), 1);
    chk("t1_err_n", 32'(err_n), 0);

    // Zero-wait store at 0x200, word pattern 0xR0W0
    sd = '0;
    for (int r = 0; r < ROWS; r++)
      for (int w = 0; w < WPR; w++)
        sd[r*ROW_BITS + 32*w +: 32] = 32'((r << 12) | (w << 4));
    run_xfer(1'b0, 1'b1, 32'h200, sd, 1'b0, busy_n, done_cyc, done_n, err_n, err_cyc);
    check_accesses(32'h200, 1'b1, sd);
    chk_wide("t2_ld_kept", ld_data_o, exp_ld);
    chk("t2_busy", 32'(busy_n), 17);
    chk("t2_done_cyc", 32'(done_cyc), 17);
    chk("t2_done_n", 32'(done_n), 1);

    // Random latencies, junk rvalid, starts poked while busy
    gmax = 5; rmax = 5; spur_en = 1'b1;
    for (int t = 0; t < 8; t++) begin
      is_ld = 1'($urandom_range(0, 1));
      base  = $urandom & 32'hFFFF_FFFC;
      for (int i = 0; i < NW; i++) sd[i*32 +: 32] = $urandom;
      run_xfer(is_ld, ~is_ld, base, sd, 1'b1, busy_n, done_cyc, done_n, err_n, err_cyc);
      check_accesses(base, ~is_ld, sd);
      if (is_ld) exp_ld = model_ld(base);
      chk_wide("rnd_ld", ld_data_o, exp_ld);
      chk("rnd_done_n", 32'(done_n), 1);
      chk("rnd_busy_end", 32'(busy_n), 32'(done_cyc));
      repeat (3) @(negedge clk);
      chk("rnd_idle_after", 32'(busy_o), 0);
      chk("rnd_no_extra", 32'(obs_addr.size()), 32'(NW));
    end
    gmax = 0; rmax = 0; spur_en = 1'b0;

    // Both starts high: load wins, store data ignored
    for (int i = 0; i < NW; i++) sd[i*32 +: 32] = $urandom;
    run_xfer(1'b1, 1'b1, 32'h500, sd, 1'b0, busy_n, done_cyc, done_n, err_n, err_cyc);
    check_accesses(32'h500, 1'b0, sd);
    exp_ld = model_ld(32'h500);
    chk_wide("both_ld", ld_data_o, exp_ld);

    // Async reset in the middle of a load
    obs_addr.delete(); obs_wdata.delete(); obs_wr.delete();
    @(posedge clk); #1;
    start_load_i = 1'b1;
    base_addr_i  = 32'h300;
    @(posedge clk); #1;
    start_load_i = 1'b0;
    guard = 0;
    while (guard < 200 && !(obs_addr.size() >= 7 && mem_req_o)) begin
      @(negedge clk);
      guard++;
    end
    chk("rst_mid_reach", 32'(guard >= 200), 0);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_req", 32'(mem_req_o), 0);
    chk("rst_mid_busy", 32'(busy_o), 0);
    chk_wide("rst_mid_ld", ld_data_o, '0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_ld = '0;
    @(negedge clk);
    run_xfer(1'b1, 1'b0, 32'h400, '0, 1'b0, busy_n, done_cyc, done_n, err_n, err_cyc);
    check_accesses(32'h400, 1'b0, '0);
    exp_ld = model_ld(32'h400);
    chk_wide("post_rst_ld", ld_data_o, exp_ld);
    chk("post_rst_busy", 32'(busy_n), 33);

    // Misaligned base
    run_xfer(1'b1, 1'b0, 32'h102, '0, 1'b0, busy_n, done_cyc, done_n, err_n, err_cyc);
`ifdef VEC_LDST_ERR_EN
    chk("mis_n_access", 32'(obs_addr.size()), 0);
    chk("mis_err_n", 32'(err_n), 1);
    chk("mis_err_cyc", 32'(err_cyc), 1);
    chk("mis_done_cyc", 32'(done_cyc), 1);
    chk("mis_busy", 32'(busy_n), 1);
    chk_wide("mis_ld_kept", ld_data_o, exp_ld);
`else
    check_accesses(32'h100, 1'b0, '0);
    exp_ld = model_ld(32'h100);
    chk_wide("mis_ld", ld_data_o, exp_ld);
    chk("mis_err_n", 32'(err_n), 0);
    chk("mis_busy", 32'(busy_n), 33);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
